// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : arb_pkg
// Arbitration mode encodings and the grant-index width helper.
// Revision : 1.0
// ============================================================================
package arb_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  // $clog2(1) is 0, so a single channel still needs a 1-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/module_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : module_rr_arbiter
// Fixed-priority or round-robin arbiter producing a one-hot grant and its index.
// Revision : 1.0
// ============================================================================
module module_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int MODE  = ARB_MODE_RR,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req,
  input  logic             advance,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic             w_found;

  // Scan from the start point upward, wrapping at N_IN-1.
  always_comb begin
    int start;
    int j;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    j         = 0;
    start     = (MODE == ARB_MODE_RR) ? int'(ptr_q) : 0;
    for (int off = 0; off < N_IN; off++) begin
      j = start + off;
      if (j >= N_IN) j = j - N_IN;
      if (!w_found && req[SEL_W'(j)]) begin
        w_found            = 1'b1;
        grant[SEL_W'(j)]   = 1'b1;
        grant_idx          = SEL_W'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE != ARB_MODE_RR) begin
      ptr_d = '0;
    end else if (advance) begin
      ptr_d = (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/module_mux_arb_n_a_1.sv
`default_nettype none
// ============================================================================
// Module   : module_mux_arb_n_a_1
// N-channel arbitrated selector with a one-entry valid/ready output register.
// Revision : 1.0
// ============================================================================
module module_mux_arb_n_a_1
  import arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 4,
  parameter  int MODE  = ARB_MODE_RR,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel
);

  logic [N_IN-1:0]  w_grant;
  logic [SEL_W-1:0] w_grant_idx;
  logic             w_can_load;
  logic             w_transfer;
  logic [WIDTH-1:0] w_ch [N_IN];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
      assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_can_load = !flush && (!out_valid_q || out_ready);
  // Gate with rst so no channel sees an accept while the block is held in reset.
  assign in_ready   = rst ? '0 : (w_grant & {N_IN{w_can_load}});
  assign w_transfer = |in_ready;

  module_rr_arbiter #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (w_transfer),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = w_ch[w_grant_idx];
      out_sel_d   = w_grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_module_mux_arb_n_a_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_module_mux_arb_n_a_1
// Directed scoreboard bench for the arbitrated selector (round-robin and fixed).
// Revision : 1.0
// ============================================================================
module tb_module_mux_arb_n_a_1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [31:0]  chd [4];
  logic [127:0] in_data;
  logic [3:0]   in_valid = 4'b0000;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   out_sel;

  logic [3:0]   f_in_valid = 4'b0000;
  logic [3:0]   f_in_ready;
  logic [31:0]  f_out_data;
  logic         f_out_valid;
  logic         f_out_ready = 1'b0;
  logic [1:0]   f_out_sel;

  int checks = 0;
  int errors = 0;
  logic [33:0] sb [$];

  assign in_data = {chd[3], chd[2], chd[1], chd[0]};

  always #5 clk = ~clk;

  module_mux_arb_n_a_1 #(.WIDTH(32), .N_IN(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  module_mux_arb_n_a_1 #(.WIDTH(32), .N_IN(4), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .flush(1'b0), .in_data(in_data),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .out_data(f_out_data),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_sel(f_out_sel)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_load(input logic [1:0] ch, input logic [31:0] d);
    sb.push_back({ch, d});
  endtask

  // Entries are checked at the cycle the consumer takes them; flush drops one.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && out_valid) begin
      if (flush) begin
        if (sb.size() > 0) e = sb.pop_front();
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got data %0h sel %0d expected none", out_data, out_sel);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 64'(out_data), 64'(e[31:0]));
          chk("sb_sel",  64'(out_sel),  64'(e[33:32]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) chd[i] = 32'hA000_0000 + i;

    // Reset with every channel requesting
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_out_sel",   64'(out_sel),   64'h0);
    tick();
    tick();
    chk("rst_hold_in_ready", 64'(in_ready), 64'h0);
    rst = 1'b0;
    #1;

    // Round-robin rotation 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      chk("rr_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
      expect_load(2'(k % 4), chd[k % 4]);
      tick();
    end
    in_valid = 4'b0000;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("drain_out_valid", 64'(out_valid), 64'h0);
    chk("drain_hold_data", 64'(out_data),  64'hA000_0000);
    chk("drain_hold_sel",  64'(out_sel),   64'h0);

    // Backpressure on a ch2 entry (ptr=1 -> ch2, ptr becomes 3)
    chd[2]    = 32'hDEAD_BEEF;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #1;
    chk("bp_load_ready", 64'(in_ready), 64'h4);
    expect_load(2'd2, 32'hDEAD_BEEF);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_data",  64'(out_data),  64'hDEAD_BEEF);
      chk("bp_hold_valid", 64'(out_valid), 64'h1);
      chk("bp_in_ready",   64'(in_ready),  64'h0);
      tick();
    end

    // Wrap from ptr=3 with requests on ch0 and ch3: 3,0,3
    out_ready = 1'b1;
    in_valid  = 4'b1001;
    #1;
    chk("wrap_g3a", 64'(in_ready), 64'h8);
    expect_load(2'd3, chd[3]);
    tick();
    chk("wrap_g0", 64'(in_ready), 64'h1);
    expect_load(2'd0, chd[0]);
    tick();
    chk("wrap_g3b", 64'(in_ready), 64'h8);
    expect_load(2'd3, chd[3]);
    tick();
    in_valid = 4'b0000;
    tick();

    // Flush while holding an entry with ch1 requesting (ptr=0 -> ch1, ptr becomes 2)
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    #1;
    chk("fl_load_ready", 64'(in_ready), 64'h2);
    expect_load(2'd1, chd[1]);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_in_ready",  64'(in_ready),  64'h0);
    chk("fl_out_valid", 64'(out_valid), 64'h1);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_after_valid", 64'(out_valid), 64'h0);
    chk("fl_after_data",  64'(out_data),  64'(chd[1]));
    chk("fl_after_ready", 64'(in_ready),  64'h2);
    expect_load(2'd1, chd[1]);
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    tick();

    // Asynchronous reset in the middle of a stall
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #1;
    expect_load(2'd2, 32'hDEAD_BEEF);
    tick();
    chk("ar_pre_valid", 64'(out_valid), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'h0);
    chk("ar_out_data",  64'(out_data),  64'h0);
    chk("ar_out_sel",   64'(out_sel),   64'h0);
    chk("ar_in_ready",  64'(in_ready),  64'h0);
    sb.delete();
    in_valid = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Fixed priority: ch1 always beats ch3
    f_in_valid  = 4'b1010;
    f_out_ready = 1'b1;
    #1;
    chk("fx_in_ready0", 64'(f_in_ready), 64'h2);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("fx_in_ready", 64'(f_in_ready),  64'h2);
      chk("fx_out_sel",  64'(f_out_sel),   64'h1);
      chk("fx_out_data", 64'(f_out_data),  64'(chd[1]));
      chk("fx_valid",    64'(f_out_valid), 64'h1);
      tick();
    end
    f_in_valid = 4'b0000;
    tick();

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/module_mux_arb_n_a_1.md
Name: module_mux_arb_n_a_1

Overview:
- Parametrised N-channel registered selector; successor to the plain combinational 4:1 data-path mux.
- Arbitrates among N valid/ready input channels in fixed-priority or round-robin mode.
- Forwards the winner through a one-entry output register with valid/ready handshake.
- Used where several pipeline sources (writeback, load return, CSR, branch-unit results) share one consumer port.

Parameters:
- WIDTH, 32, data width per channel in bits.
- N_IN, 4, number of input channels; legal range 1..16.
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round robin.
- SEL_W, (N_IN > 1) ? $clog2(N_IN) : 1, width of the granted-index output; derived, not to be overridden.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous pipeline flush; drops the registered entry.
- in_data, input, N_IN*WIDTH, packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, N_IN, per-channel request.
- in_ready, output, N_IN, per-channel accept; combinational.
- out_data, output, WIDTH, registered selected data.
- out_valid, output, 1, out_data holds a valid entry.
- out_ready, input, 1, consumer accepts out_data this cycle.
- out_sel, output, SEL_W, index of the channel that produced the current out_data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, round-robin pointer=0, in_ready=0 while rst is high.
- can_load = !flush && (!out_valid || out_ready).
- Grant, fixed mode: lowest index i with in_valid[i]=1.
- Grant, round-robin mode: first i with in_valid[i]=1, scanning from ptr upward and wrapping N_IN-1 -> 0.
- Grant is one-hot or zero.
- in_ready[i] = grant[i] && can_load. At most one in_ready bit is high per cycle.
- Transfer on input i occurs when in_valid[i] && in_ready[i]. On the next edge: out_data <= channel i data, out_sel <= i, out_valid <= 1.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Full throughput: one transfer per cycle when out_ready is held at 1.
- Output consumed with no new transfer (out_valid && out_ready, no input transfer): out_valid <= 0; out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): out_data, out_sel and out_valid hold stable; all in_ready are 0.
- Round-robin pointer: after a transfer from channel i, ptr <= (i == N_IN-1) ? 0 : i+1. The pointer is unchanged when there is no transfer. In fixed mode the pointer is unused and stays 0.
- Flush (synchronous): next edge out_valid <= 0. in_ready is forced to 0 in the flush cycle, so no transfer occurs. ptr and out_data are unchanged.
- Flush has priority over out_ready and over any pending grant.
- Simultaneous consume and load: out_valid stays 1 and the new data replaces the old on the same edge.
- No requests (in_valid all 0): no grant, in_ready all 0, ptr unchanged.
- N_IN=1: grant = in_valid[0]; out_sel is constant 0; mode has no effect.
- Reset mid-transfer: the entry is discarded and the block returns to reset values asynchronously. No partial state survives.
- The selected channel's in_valid/in_data must be stable only in its own transfer cycle; there is no internal buffering beyond the one output entry.

Decomposition:
- Shared package (arb_pkg):
  - ARB_MODE_FIXED = 0, ARB_MODE_RR = 1.
  - Function sel_width(n) returning max(1, $clog2(n)).
- Sub-module module_rr_arbiter: parameters N_IN and MODE.
  - Inputs: req[N_IN], advance, clk, rst.
  - Outputs: grant one-hot [N_IN], grant_idx [SEL_W].
  - Owns the pointer register.
- Top level owns the output register, handshake and flush, and muxes in_data by grant_idx.

Test Plan:
- Reset with in_valid=4'b1111 asserted: out_valid=0, out_data=0, in_ready=0 during reset. After release (MODE=1), grants in order 0,1,2,3,0 over five cycles with out_ready=1; out_sel follows one cycle later.
- MODE=0, in_valid=4'b1010 held, out_ready=1: only channel 1 ever sees in_ready=1. Channel 3 is starved and out_sel stays 1.
- Backpressure: load ch2 data 32'hDEADBEEF, then out_ready=0 for 3 cycles. out_data holds DEADBEEF, out_valid=1, in_ready=0 all three cycles; ptr stays 3.
- Wrap: MODE=1, ptr=3, in_valid=4'b1001. Grant ch3, then ch0, then ch3; ptr sequence 0,1,0.
- Flush with out_valid=1 and ch1 requesting: next cycle out_valid=0, no transfer, ptr unchanged. Following cycle ch1 is granted normally.
- Async reset asserted mid-stall (out_valid=1, out_ready=0): outputs clear within the same cycle, without waiting for a clock edge.
